// File: rtl/prog_mem_if.sv
// Processor memory bus plus program-image load port shared by prog_mem and its driver.
// master drives address/data and load words; slave is the memory responder.
interface prog_mem_if #(
    parameter int DATA_W = 16
);
    logic              we;
    logic [15:0]       addr;
    logic [DATA_W-1:0] toMem;
    logic [DATA_W-1:0] fromMem;
    logic              load_valid;
    logic              load_ready;
    logic [DATA_W-1:0] load_data;
    logic              load_last;

    modport master (
        output we, addr, toMem, load_valid, load_data, load_last,
        input  fromMem, load_ready
    );

    modport slave (
        input  we, addr, toMem, load_valid, load_data, load_last,
        output fromMem, load_ready
    );
endinterface

// File: rtl/prog_mem.sv
// Word-addressed program/data memory: zero-fills after reset, loads an image while
// holding the processor in reset, then serves processor reads/writes with 1-cycle latency.
//
// state | meaning
// CLEAR | writing zero to every word, one per cycle; processor ignored
// LOAD  | accepting image words on the load port; processor held in reset
// RUN   | processor released; registered reads, writes on we; terminal until rst
module prog_mem #(
    parameter int DEPTH_LOG2 = 8,
    parameter int DATA_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    prog_mem_if.slave         bus,
    output logic              cpu_rst,
    output logic [DATA_W-1:0] words_loaded,
    output logic              err_oob
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2
    } state_t;

    state_t                  state, state_nxt;
    logic [DEPTH_LOG2-1:0]   ptr, ptr_nxt;
    logic [DATA_W-1:0]       wl_nxt;
    logic                    load_ready_q;
    logic                    oob_hit;
    logic                    mem_we;
    logic [DEPTH_LOG2-1:0]   mem_waddr;
    logic [DATA_W-1:0]       mem_wdata;
    logic [DATA_W-1:0]       mem [DEPTH];

    logic [DEPTH_LOG2-1:0]   cpu_idx;
    logic                    cpu_oob;
    logic                    xfer;

    assign cpu_idx        = bus.addr[DEPTH_LOG2-1:0];
    assign cpu_oob        = |bus.addr[15:DEPTH_LOG2];
    assign xfer           = (state == LOAD) && bus.load_valid && load_ready_q;
    assign bus.load_ready = load_ready_q;

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        wl_nxt    = words_loaded;
        mem_we    = 1'b0;
        mem_waddr = ptr;
        mem_wdata = '0;
        oob_hit   = 1'b0;
        case (state)
            CLEAR: begin
                mem_we  = 1'b1;
                ptr_nxt = ptr + 1'b1;
                if (&ptr) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                if (xfer) begin
                    mem_we    = 1'b1;
                    mem_wdata = bus.load_data;
                    ptr_nxt   = ptr + 1'b1;
                    if (words_loaded != DATA_W'(DEPTH)) begin
                        wl_nxt = words_loaded + 1'b1;
                    end
                    // the last slot ends the load even without load_last so ptr never wraps
                    if (bus.load_last || (&ptr)) begin
                        state_nxt = RUN;
                    end
                end
            end
            RUN: begin
                oob_hit   = cpu_oob;
                mem_waddr = cpu_idx;
                mem_wdata = bus.toMem;
                mem_we    = bus.we && !cpu_oob;
            end
            default: begin
                state_nxt = CLEAR;
                ptr_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= CLEAR;
            ptr          <= '0;
            words_loaded <= '0;
            load_ready_q <= 1'b0;
            cpu_rst      <= 1'b1;
            err_oob      <= 1'b0;
        end else begin
            state        <= state_nxt;
            ptr          <= ptr_nxt;
            words_loaded <= wl_nxt;
            load_ready_q <= (state_nxt == LOAD);
            cpu_rst      <= (state_nxt != RUN);
            if (oob_hit) begin
                err_oob <= 1'b1;
            end
        end
    end

    // read-before-write falls out of the nonblocking update of mem
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.fromMem <= '0;
        end else if (state == RUN && !cpu_oob) begin
            bus.fromMem <= mem[cpu_idx];
        end else begin
            bus.fromMem <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end
endmodule
